// File: rtl/panel_cmd_pkg.sv
// Shared constants for the PDP-8/e front-panel command block: halt encoding,
// timeout default, command FSM encodings and the strobe bundle.
package panel_cmd_pkg;

  localparam int unsigned WORD_W = 12;
  localparam int unsigned ADDR_W = 15;

  localparam logic [4:0]  HALT_STATE_DEF  = 5'd0;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MREQ = 2'd1;
  localparam logic [1:0] ST_INC  = 2'd2;

  // Field order is the accept priority, highest first.
  typedef struct packed {
    logic clear;
    logic extd;
    logic addr;
    logic dep;
    logic exam;
    logic cont;
  } strobes_t;

  // Console PC wraps 7777 -> 0000 within the current field.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(1);
  endfunction

endpackage

// File: rtl/panel_cmd_if.sv
// Single-request console memory port: level request held until ack,
// address/data/we stable for the whole request.
interface panel_cmd_if;
  import panel_cmd_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/panel_cmd.sv
// PDP-8/e console command executor: Addr Load, Extd Addr Load, Deposit,
// Examine, Cont, Clear. Optional memory-ack timeout under PANEL_TIMEOUT_EN.
module panel_cmd
  import panel_cmd_pkg::*;
#(
  parameter logic [4:0] HALT_STATE = HALT_STATE_DEF
`ifdef PANEL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        state,
  input  logic              triggerd,
  input  logic              cleard,
  input  logic              extd_addrd,
  input  logic              addr_loadd,
  input  logic              depd,
  input  logic              examd,
  input  logic              contd,
  input  logic [WORD_W-1:0] sr,
  panel_cmd_if.master       mem,
  output logic [WORD_W-1:0] pc,
  output logic [2:0]        ifr,
  output logic [2:0]        dfr,
  output logic [WORD_W-1:0] mb,
  output logic              run_req,
  output logic              clear_req,
  output logic              busy,
  output logic              err
);

  strobes_t stb;
  logic     halted;

  logic [1:0]        st_q, st_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [2:0]        ifr_q, ifr_d;
  logic [2:0]        dfr_q, dfr_d;
  logic [WORD_W-1:0] mb_q, mb_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              run_q, run_d;
  logic              clr_q, clr_d;

`ifdef PANEL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign stb    = '{clear: cleard, extd: extd_addrd, addr: addr_loadd,
                    dep: depd, exam: examd, cont: contd};
  assign halted = (state == HALT_STATE);

  always_comb begin
    st_d    = st_q;
    pc_d    = pc_q;
    ifr_d   = ifr_q;
    dfr_d   = dfr_q;
    mb_d    = mb_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    run_d   = 1'b0;
    clr_d   = 1'b0;
`ifdef PANEL_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (triggerd) begin
          if (stb.clear) begin
            clr_d = 1'b1;
`ifdef PANEL_TIMEOUT_EN
            err_d = 1'b0;
`endif
          end else if (halted) begin
            if (stb.extd) begin
              // sr[11] is PDP-8 bit 0, so bits 6-8 / 9-11 are the low two octal digits.
              ifr_d = sr[5:3];
              dfr_d = sr[2:0];
            end else if (stb.addr) begin
              pc_d = sr;
            end else if (stb.dep) begin
              st_d    = ST_MREQ;
              wdata_d = sr;
              we_d    = 1'b1;
`ifdef PANEL_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end else if (stb.exam) begin
              st_d = ST_MREQ;
              we_d = 1'b0;
`ifdef PANEL_TIMEOUT_EN
              cnt_d = '0;
`endif
            end else if (stb.cont) begin
              run_d = 1'b1;
            end
          end
        end
      end
      ST_MREQ: begin
        if (mem.ack) begin
          mb_d = we_q ? wdata_q : mem.rdata;
          st_d = ST_INC;
        end
`ifdef PANEL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          st_d  = ST_IDLE;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_INC: begin
        pc_d = pc_inc(pc_q);
        st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q    <= ST_IDLE;
      pc_q    <= '0;
      ifr_q   <= '0;
      dfr_q   <= '0;
      mb_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      ifr_q   <= ifr_d;
      dfr_q   <= dfr_d;
      mb_q    <= mb_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
    end
  end

`ifdef PANEL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem.req   = (st_q == ST_MREQ);
  assign mem.we    = (st_q == ST_MREQ) & we_q;
  assign mem.addr  = {ifr_q, pc_q};
  assign mem.wdata = wdata_q;

  assign pc        = pc_q;
  assign ifr       = ifr_q;
  assign dfr       = dfr_q;
  assign mb        = mb_q;
  assign run_req   = run_q;
  assign clear_req = clr_q;
  assign busy      = (st_q != ST_IDLE);

endmodule

// File: tb/tb_panel_cmd.sv
// Directed bench for panel_cmd; timeout checks compile in when
// PANEL_TIMEOUT_EN is defined, otherwise the indefinite wait is checked.
module tb_panel_cmd;
  import panel_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  state;
  logic        triggerd;
  logic        cleard, extd_addrd, addr_loadd, depd, examd, contd;
  logic [11:0] sr;
  logic [11:0] pc, mb;
  logic [2:0]  ifr, dfr;
  logic        run_req, clear_req, busy, err;

  int total = 0;
  int bad   = 0;

  panel_cmd_if mif();

  panel_cmd dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .triggerd   (triggerd),
    .cleard     (cleard),
    .extd_addrd (extd_addrd),
    .addr_loadd (addr_loadd),
    .depd       (depd),
    .examd      (examd),
    .contd      (contd),
    .sr         (sr),
    .mem        (mif),
    .pc         (pc),
    .ifr        (ifr),
    .dfr        (dfr),
    .mb         (mb),
    .run_req    (run_req),
    .clear_req  (clear_req),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0o exp=%0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Strobe bits: {clear, extd, addr, dep, exam, cont}; one accept edge.
  task automatic cmd(input logic [5:0] s, input logic [11:0] sw);
    $display("cmd strobes=%b sr=%04o state=%0d", s, sw, state);
    sr = sw;
    triggerd = 1'b1;
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = s;
    tick();
    triggerd = 1'b0;
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    state = HALT_STATE_DEF;
    triggerd = 1'b0;
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'b0;
    sr = '0;
    mif.ack = 1'b0;
    mif.rdata = '0;
    tick(); tick();
    chk("rst_pc", pc, 0);
    chk("rst_ifr", ifr, 0);
    chk("rst_mb", mb, 0);
    chk("rst_req", mif.req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {run_req, clear_req, err}, 0);
    reset = 1'b1;
    tick();

    cmd(6'b001000, 12'o1234);
    chk("aload_pc", pc, 12'o1234);
    chk("aload_req", mif.req, 0);
    chk("aload_busy", busy, 0);

    cmd(6'b010000, 12'o0025);
    chk("extd_ifr", ifr, 2);
    chk("extd_dfr", dfr, 5);
    cmd(6'b001000, 12'o0100);

    // Deposit with two wait cycles before ack
    cmd(6'b000100, 12'o5555);
    chk("dep_req", mif.req, 1);
    chk("dep_we", mif.we, 1);
    chk("dep_addr", mif.addr, 15'o20100);
    chk("dep_wdata", mif.wdata, 12'o5555);
    chk("dep_busy", busy, 1);
    sr = 12'o7070;
    tick();
    tick();
    chk("dep_wait_req", mif.req, 1);
    chk("dep_wait_wdata", mif.wdata, 12'o5555);
    mif.ack = 1'b1;
    tick();
    mif.ack = 1'b0;
    $display("txn write addr=%05o data=%04o", 15'o20100, 12'o5555);
    chk("dep_inc_req", mif.req, 0);
    chk("dep_inc_busy", busy, 1);
    chk("dep_mb", mb, 12'o5555);
    tick();
    chk("dep_pc", pc, 12'o0101);
    chk("dep_idle_busy", busy, 0);

    // Examine at the top of the field: PC wraps, IF stays
    cmd(6'b001000, 12'o7777);
    cmd(6'b010000, 12'o0030);
    cmd(6'b000010, 12'o0000);
    chk("exam_req", mif.req, 1);
    chk("exam_we", mif.we, 0);
    chk("exam_addr", mif.addr, 15'o37777);
    mif.ack = 1'b1;
    mif.rdata = 12'o4321;
    tick();
    mif.ack = 1'b0;
    mif.rdata = '0;
    $display("txn read addr=%05o data=%04o", 15'o37777, 12'o4321);
    chk("exam_mb", mb, 12'o4321);
    tick();
    chk("exam_pc_wrap", pc, 12'o0000);
    chk("exam_ifr", ifr, 3);
    chk("exam_busy", busy, 0);

    // Stray ack in IDLE does nothing
    mif.ack = 1'b1;
    mif.rdata = 12'o1111;
    tick();
    mif.ack = 1'b0;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_mb", mb, 12'o4321);

    cmd(6'b001110, 12'o2222);
    chk("prio_pc", pc, 12'o2222);
    chk("prio_req", mif.req, 0);
    chk("prio_busy", busy, 0);

    cmd(6'b100001, 12'o0000);
    chk("prio_clr", {clear_req, run_req}, 2'b10);
    tick();

    // CPU running
    state = 5'd3;
    cmd(6'b000100, 12'o3333);
    chk("run_dep_req", mif.req, 0);
    chk("run_dep_busy", busy, 0);
    cmd(6'b001000, 12'o3333);
    chk("run_aload_pc", pc, 12'o2222);
    cmd(6'b100000, 12'o0000);
    chk("run_clr_pulse", clear_req, 1);
    tick();
    chk("run_clr_end", clear_req, 0);
    state = HALT_STATE_DEF;

    cmd(6'b000001, 12'o0000);
    chk("cont_pulse", run_req, 1);
    tick();
    chk("cont_end", run_req, 0);

    // Strobes without triggerd are not commands
    sr = 12'o6543;
    addr_loadd = 1'b1;
    tick();
    addr_loadd = 1'b0;
    chk("notrig_pc", pc, 12'o2222);

    // Reset in the middle of a request
    cmd(6'b001000, 12'o0400);
    cmd(6'b000100, 12'o1111);
    chk("rmid_req_before", mif.req, 1);
    reset = 1'b0;
    tick();
    chk("rmid_req", mif.req, 0);
    chk("rmid_pc", pc, 0);
    chk("rmid_mb", mb, 0);
    reset = 1'b1;
    tick();

`ifdef PANEL_TIMEOUT_EN
    cmd(6'b000100, 12'o0707);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mif.req) break;
      n++;
      tick();
    end
    $display("txn timeout after %0d request cycles", n);
    chk("to_req_cycles", n, 16);
    chk("to_err", err, 1);
    chk("to_pc", pc, 0);
    chk("to_mb", mb, 0);
    chk("to_busy", busy, 0);
    cmd(6'b100000, 12'o0000);
    chk("to_err_clr", err, 0);
`else
    cmd(6'b000100, 12'o0707);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (mif.req) n++;
      tick();
    end
    chk("wait_req_cycles", n, 20);
    chk("wait_err", err, 0);
    mif.ack = 1'b1;
    tick();
    mif.ack = 1'b0;
    $display("txn write addr=%05o data=%04o", 15'o00000, 12'o0707);
    tick();
    chk("wait_pc", pc, 1);
    chk("wait_mb", mb, 12'o0707);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
